// File: rtl/lsu_writeback_pkg.sv
// Shared definitions for the load/store writeback unit: state encoding,
// RISC-V load/store width codes and the legality/alignment check.
package lsu_writeback_pkg;

   typedef enum logic [1:0] {IDLE, REQ, RESP, WB} lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // True when funct3 is a legal width for this kind of access and the
   // low address bits satisfy its natural alignment.
   function automatic logic op_legal(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] lo);
      logic ok;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = !lo[0];
         F3_W:    ok = (lo == 2'b00);
         F3_BU:   ok = !is_store;
         F3_HU:   ok = !is_store && !lo[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte-lane strobes for a store of the given width at byte offset lo.
   function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
      logic [3:0] s;
      case (f3[1:0])
         2'b00:   s = 4'b0001 << lo;
         2'b01:   s = 4'b0011 << lo;
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/lsu_writeback_if.sv
// Execute-side request, data-memory bus and register-file write port of the
// load/store unit, bundled so the unit and its environment share one view.
interface lsu_writeback_if #(
   parameter int XLEN      = 32,
   parameter int RF_ADDR_W = 5
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_is_store;
   logic [2:0]           req_funct3;
   logic [XLEN-1:0]      req_addr;
   logic [XLEN-1:0]      req_sdata;
   logic [RF_ADDR_W-1:0] req_rd;

   logic                 mem_req;
   logic                 mem_we;
   logic [XLEN-1:0]      mem_addr;
   logic [3:0]           mem_wstrb;
   logic [XLEN-1:0]      mem_wdata;
   logic                 mem_gnt;
   logic                 mem_rvalid;
   logic [XLEN-1:0]      mem_rdata;

   logic                 reg_wr;
   logic [RF_ADDR_W-1:0] waddr;
   logic [XLEN-1:0]      wdata;
   logic                 fault;

   // The load/store unit itself.
   modport master (
      input  req_valid, req_is_store, req_funct3, req_addr, req_sdata, req_rd,
      output req_ready,
      output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output reg_wr, waddr, wdata, fault
   );

   // Execute stage, data memory and register file around it.
   modport slave (
      output req_valid, req_is_store, req_funct3, req_addr, req_sdata, req_rd,
      input  req_ready,
      input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  reg_wr, waddr, wdata, fault
   );
endinterface

// File: rtl/lsu_writeback_load_align.sv
// Combinational load alignment: picks the addressed byte/half out of the
// returned word and sign- or zero-extends it. Also used by the single-cycle
// core's data path, so it carries no state.
module lsu_writeback_load_align
   import lsu_writeback_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select followed by width-dependent extension.
   always_comb begin
      byte_sel = rdata[{offset, 3'b000} +: 8];
      half_sel = rdata[{offset[1], 4'b0000} +: 16];
      case (funct3)
         F3_B:    result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_H:    result = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_BU:   result = {{(XLEN-8){1'b0}}, byte_sel};
         F3_HU:   result = {{(XLEN-16){1'b0}}, half_sel};
         default: result = rdata;
      endcase
   end
endmodule

// File: rtl/lsu_writeback.sv
// Load/store unit: takes one operation from execute, runs the data-memory
// request/grant/response handshake and, for loads, writes the aligned result
// to the register file in a single-cycle WB state. All outputs are registered.
module lsu_writeback
   import lsu_writeback_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int RF_ADDR_W = 5
) (
   input logic           clk,
   input logic           rst_n,
   lsu_writeback_if.master bus
);
   lsu_state_t           state;
   logic                 op_store;
   logic [2:0]           op_funct3;
   logic [1:0]           op_offset;
   logic [RF_ADDR_W-1:0] op_rd;

   logic [XLEN-1:0]      load_result;
   logic [XLEN-1:0]      store_wdata;
   logic                 accept;

   assign accept = bus.req_valid && bus.req_ready;

   lsu_writeback_load_align #(.XLEN(XLEN)) u_align (
      .rdata  (bus.mem_rdata),
      .offset (op_offset),
      .funct3 (op_funct3),
      .result (load_result)
   );

   // Replicate store data across lanes so the strobes alone pick the bytes.
   always_comb begin
      case (bus.req_funct3[1:0])
         2'b00:   store_wdata = {(XLEN/8){bus.req_sdata[7:0]}};
         2'b01:   store_wdata = {(XLEN/16){bus.req_sdata[15:0]}};
         default: store_wdata = bus.req_sdata;
      endcase
   end

   // Operation sequencer; bus and writeback outputs are driven from here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         op_store      <= 1'b0;
         op_funct3     <= 3'b000;
         op_offset     <= 2'b00;
         op_rd         <= '0;
         bus.req_ready <= 1'b1;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wstrb <= 4'b0000;
         bus.mem_wdata <= '0;
         bus.reg_wr    <= 1'b0;
         bus.waddr     <= '0;
         bus.wdata     <= '0;
         bus.fault     <= 1'b0;
      end else begin
         // fault and reg_wr are pulses: cleared unless set below.
         bus.fault  <= 1'b0;
         bus.reg_wr <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!op_legal(bus.req_is_store, bus.req_funct3, bus.req_addr[1:0])) begin
                     bus.fault <= 1'b1;
                  end else begin
                     op_store      <= bus.req_is_store;
                     op_funct3     <= bus.req_funct3;
                     op_offset     <= bus.req_addr[1:0];
                     op_rd         <= bus.req_rd;
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= bus.req_is_store;
                     bus.mem_addr  <= {bus.req_addr[XLEN-1:2], 2'b00};
                     bus.mem_wstrb <= bus.req_is_store ?
                                      store_strb(bus.req_funct3, bus.req_addr[1:0]) : 4'b0000;
                     bus.mem_wdata <= bus.req_is_store ? store_wdata : '0;
                     bus.req_ready <= 1'b0;
                     state         <= REQ;
                  end
               end
            end
            REQ: begin
               if (bus.mem_gnt) begin
                  bus.mem_req <= 1'b0;
                  bus.mem_we  <= 1'b0;
                  if (op_store) begin
                     bus.req_ready <= 1'b1;
                     state         <= IDLE;
                  end else begin
                     state <= RESP;
                  end
               end
            end
            RESP: begin
               if (bus.mem_rvalid) begin
                  bus.wdata  <= load_result;
                  bus.waddr  <= op_rd;
                  bus.reg_wr <= (op_rd != '0);
                  state      <= WB;
               end
            end
            WB: begin
               bus.req_ready <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_writeback.sv
// Directed bench for lsu_writeback: loads of every width, stores with wait
// states, fault cases, rd=0 and reset in the middle of a load.
module tb_lsu_writeback;
   import lsu_writeback_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   lsu_writeback_if #(.XLEN(32), .RF_ADDR_W(5)) bus ();

   lsu_writeback #(.XLEN(32), .RF_ADDR_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus.req_valid    = 1'b0;
      bus.req_is_store = 1'b0;
      bus.req_funct3   = 3'b000;
      bus.req_addr     = 32'h0;
      bus.req_sdata    = 32'h0;
      bus.req_rd       = 5'd0;
      bus.mem_gnt      = 1'b0;
      bus.mem_rvalid   = 1'b0;
      bus.mem_rdata    = 32'h0;
   endtask

   task automatic test_reset();
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready got %0b want 1", bus.req_ready);
      end
      n_cmp++;
      if ({bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.reg_wr, bus.fault} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_ctrl got %b want 00000000",
                  {bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.reg_wr, bus.fault});
      end
      n_cmp++;
      if ({bus.mem_addr, bus.mem_wdata, bus.waddr, bus.wdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_data got addr=%h wd=%h waddr=%0d wdata=%h want all 0",
                  bus.mem_addr, bus.mem_wdata, bus.waddr, bus.wdata);
      end
      n_cmp++;
      if (dut.state !== IDLE) begin
         n_fail++; $display("FAIL reset_state got %0d want IDLE", dut.state);
      end
      $display("reset: ready=%0b mem_req=%0b reg_wr=%0b", bus.req_ready, bus.mem_req, bus.reg_wr);
   endtask

   // Zero-wait load; checks mem_req at cycle 1 and reg_wr at cycle 3.
   task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp_wdata, input logic exp_wr);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_rd = rd; bus.req_sdata = 32'h5555_5555;
      @(negedge clk);
      bus.req_valid = 1'b0;
      n_cmp++;
      if ({bus.mem_req, bus.req_ready, bus.mem_we, bus.mem_wstrb} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL %s_req got req/ready/we/strb=%b want 1000000", name,
                  {bus.mem_req, bus.req_ready, bus.mem_we, bus.mem_wstrb});
      end
      n_cmp++;
      if (bus.mem_addr !== {addr[31:2], 2'b00}) begin
         n_fail++; $display("FAIL %s_addr got %h want %h", name, bus.mem_addr, {addr[31:2], 2'b00});
      end
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      n_cmp++;
      if ({bus.mem_req, bus.reg_wr} !== 2'b00) begin
         n_fail++; $display("FAIL %s_resp got mem_req/reg_wr=%b want 00", name, {bus.mem_req, bus.reg_wr});
      end
      bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
      @(negedge clk);
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'hA5A5_5A5A;
      n_cmp++;
      if (bus.reg_wr !== exp_wr || bus.waddr !== rd || bus.wdata !== exp_wdata) begin
         n_fail++;
         $display("FAIL %s_wb got wr=%0b waddr=%0d wdata=%h want wr=%0b waddr=%0d wdata=%h",
                  name, bus.reg_wr, bus.waddr, bus.wdata, exp_wr, rd, exp_wdata);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.reg_wr, bus.req_ready} !== 2'b01) begin
         n_fail++; $display("FAIL %s_done got reg_wr/ready=%b want 01", name, {bus.reg_wr, bus.req_ready});
      end
      $display("load %s f3=%b addr=%h rd=%0d rdata=%h -> wdata=%h", name, f3, addr, rd, rdata, bus.wdata);
   endtask

   task automatic run_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input int gnt_wait,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_sdata = sdata; bus.req_rd = 5'd7;
      @(negedge clk);
      bus.req_valid = 1'b0; bus.req_sdata = 32'h0; bus.req_addr = 32'hFFFF_FFFF;
      for (int i = 0; i <= gnt_wait; i++) begin
         n_cmp++;
         if ({bus.mem_req, bus.mem_we, bus.req_ready, bus.reg_wr} !== 4'b1100 ||
             bus.mem_addr !== {addr[31:2], 2'b00} || bus.mem_wstrb !== exp_strb ||
             bus.mem_wdata !== exp_wdata) begin
            n_fail++;
            $display("FAIL %s_hold%0d got req/we/ready/wr=%b addr=%h strb=%b wd=%h want 1100 addr=%h strb=%b wd=%h",
                     name, i, {bus.mem_req, bus.mem_we, bus.req_ready, bus.reg_wr}, bus.mem_addr,
                     bus.mem_wstrb, bus.mem_wdata, {addr[31:2], 2'b00}, exp_strb, exp_wdata);
         end
         if (i == gnt_wait) bus.mem_gnt = 1'b1;
         @(negedge clk);
      end
      bus.mem_gnt = 1'b0;
      n_cmp++;
      if ({bus.mem_req, bus.req_ready, bus.reg_wr} !== 3'b010) begin
         n_fail++;
         $display("FAIL %s_done got req/ready/wr=%b want 010", name, {bus.mem_req, bus.req_ready, bus.reg_wr});
      end
      $display("store %s f3=%b addr=%h sdata=%h waits=%0d strb=%b wdata=%h", name, f3, addr, sdata,
               gnt_wait, exp_strb, exp_wdata);
   endtask

   task automatic test_fault(input string name, input logic is_store, input logic [2:0] f3,
                             input logic [31:0] addr);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_is_store = is_store; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_rd = 5'd3; bus.req_sdata = 32'h1111_2222;
      @(negedge clk);
      bus.req_valid = 1'b0;
      n_cmp++;
      if ({bus.fault, bus.mem_req, bus.req_ready} !== 3'b101) begin
         n_fail++; $display("FAIL %s_pulse got fault/req/ready=%b want 101", name,
                            {bus.fault, bus.mem_req, bus.req_ready});
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.fault, bus.mem_req, bus.req_ready} !== 3'b001) begin
         n_fail++; $display("FAIL %s_after got fault/req/ready=%b want 001", name,
                            {bus.fault, bus.mem_req, bus.req_ready});
      end
      $display("fault %s st=%0b f3=%b addr=%h", name, is_store, f3, addr);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = F3_W;
      bus.req_addr = 32'h0000_0400; bus.req_rd = 5'd9;
      @(negedge clk);
      bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      n_cmp++;
      if (dut.state !== RESP) begin
         n_fail++; $display("FAIL rstmid_inresp got %0d want RESP", dut.state);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.mem_req, bus.reg_wr, bus.req_ready} !== 3'b001 || bus.mem_addr !== 32'h0) begin
         n_fail++; $display("FAIL rstmid_async got req/wr/ready=%b addr=%h want 001 addr=0",
                            {bus.mem_req, bus.reg_wr, bus.req_ready}, bus.mem_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      n_cmp++;
      if (bus.reg_wr !== 1'b0 || bus.wdata !== 32'h0 || bus.req_ready !== 1'b1 || dut.state !== IDLE) begin
         n_fail++; $display("FAIL rstmid_stray got wr=%0b wdata=%h ready=%0b state=%0d want 0 0 1 IDLE",
                            bus.reg_wr, bus.wdata, bus.req_ready, dut.state);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.reg_wr !== 1'b0 || bus.mem_req !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_quiet got wr=%0b req=%0b want 0 0", bus.reg_wr, bus.mem_req);
      end
      $display("reset mid-load: stray rvalid ignored, wdata=%h", bus.wdata);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b1;
      clear_inputs();
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      test_reset();
      rst_n = 1'b1;

      run_load("lw",  F3_W,  32'h0000_0100, 5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
      run_load("lb",  F3_B,  32'h0000_0103, 5'd6,  32'h8011_2233, 32'hFFFF_FF80, 1'b1);
      run_load("lbu", F3_BU, 32'h0000_0103, 5'd7,  32'h8011_2233, 32'h0000_0080, 1'b1);
      run_load("lb1", F3_B,  32'h0000_0101, 5'd8,  32'h8011_2233, 32'h0000_0022, 1'b1);
      run_load("lh",  F3_H,  32'h0000_0102, 5'd10, 32'h8011_2233, 32'hFFFF_8011, 1'b1);
      run_load("lhu", F3_HU, 32'h0000_0102, 5'd11, 32'h8011_2233, 32'h0000_8011, 1'b1);
      run_load("lh0", F3_H,  32'h0000_0100, 5'd12, 32'h8011_A233, 32'hFFFF_A233, 1'b1);

      run_store("sh",  F3_H, 32'h0000_0202, 32'h1234_ABCD, 3, 4'b1100, 32'hABCD_ABCD);
      run_store("sw",  F3_W, 32'h0000_0300, 32'h0BAD_F00D, 0, 4'b1111, 32'h0BAD_F00D);
      run_store("sb",  F3_B, 32'h0000_0302, 32'h0000_00E7, 1, 4'b0100, 32'hE7E7_E7E7);

      test_fault("lw_mis", 1'b0, F3_W, 32'h0000_0101);
      test_fault("sh_mis", 1'b1, F3_H, 32'h0000_0003);
      test_fault("f3_011", 1'b0, 3'b011, 32'h0000_0100);
      test_fault("sbu_ill", 1'b1, F3_BU, 32'h0000_0100);

      run_load("rd0", F3_W, 32'h0000_0500, 5'd0, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0);

      test_reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
